// File: rtl/addsub16_slice_sequencer_if.sv
// Request/response bundle for the slice-serial add/subtract engine.
// Latency: n/a (wires only). Backpressure: valid/ready on both request and response.
// Ports: req_valid/req_ready/mode/A/B (request), resp_valid/resp_ready/D/C_out/V (response).
interface addsub16_slice_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             req_valid;
  logic             req_ready;
  logic             mode;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] D;
  logic             C_out;
  logic             V;

  // Requester / consumer side.
  modport master (
    output req_valid, mode, A, B, resp_ready,
    input  req_ready, resp_valid, D, C_out, V
  );

  // Engine side.
  modport slave (
    input  req_valid, mode, A, B, resp_ready,
    output req_ready, resp_valid, D, C_out, V
  );
endinterface

// File: rtl/addsub16_slice_sequencer.sv
// Multi-cycle WIDTH-bit add/subtract through one shared SLICE-bit ripple slice, LSB first.
// Latency: result valid WIDTH/SLICE edges after the accept edge.
// Backpressure: holds in DONE with stable outputs while resp_ready=0; requests ignored while busy.
// Ports: clk, rst (async active-high), bus (slave modport: request in, result out).
// Optional macro BACK_TO_BACK_EN: in DONE, req_ready follows resp_ready so a retire and a
// new accept can share one edge; undefined, every transaction passes through IDLE.
module addsub16_slice_sequencer #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  addsub16_slice_sequencer_if.slave     bus
);
  localparam int NSL = WIDTH / SLICE;
  localparam int IW  = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [IW-1:0] LAST = IW'(NSL - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] d_reg;
  logic             c_reg;
  logic             v_reg;
  logic             rdy_reg;

  logic [SLICE-1:0] a_sl;
  logic [SLICE-1:0] b_sl;
  logic [SLICE-1:0] sum;
  logic [SLICE:0]   cc;
  logic             accept;

  assign a_sl = a_reg[idx*SLICE +: SLICE];
  assign b_sl = b_reg[idx*SLICE +: SLICE];

  // The single shared full-adder chain.
  always_comb begin
    sum   = '0;
    cc    = '0;
    cc[0] = carry;
    for (int i = 0; i < SLICE; i++) begin
      sum[i]  = a_sl[i] ^ b_sl[i] ^ cc[i];
      cc[i+1] = (a_sl[i] & b_sl[i]) | ((a_sl[i] | b_sl[i]) & cc[i]);
    end
  end

`ifdef BACK_TO_BACK_EN
  assign bus.req_ready = rdy_reg | ((state == DONE) & bus.resp_ready);
`else
  assign bus.req_ready = rdy_reg;
`endif

  assign accept         = bus.req_valid & bus.req_ready;
  assign bus.resp_valid = (state == DONE);
  assign bus.D          = d_reg;
  assign bus.C_out      = c_reg;
  assign bus.V          = v_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      carry   <= 1'b0;
      a_reg   <= '0;
      b_reg   <= '0;
      d_reg   <= '0;
      c_reg   <= 1'b0;
      v_reg   <= 1'b0;
      rdy_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rdy_reg <= 1'b1;
          if (accept) begin
            // Subtraction is A + ~B + 1: invert B here, inject the +1 as the initial carry.
            a_reg   <= bus.A;
            b_reg   <= bus.mode ? ~bus.B : bus.B;
            carry   <= bus.mode;
            idx     <= '0;
            d_reg   <= '0;
            rdy_reg <= 1'b0;
            state   <= RUN;
          end
        end
        RUN: begin
          d_reg[idx*SLICE +: SLICE] <= sum;
          carry                     <= cc[SLICE];
          idx                       <= idx + IW'(1);
          if (idx == LAST) begin
            c_reg <= cc[SLICE];
            // sum[SLICE-1] is the result MSB on the last slice.
            v_reg <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (sum[SLICE-1] != a_reg[WIDTH-1]);
            state <= DONE;
          end
        end
        DONE: begin
          if (bus.resp_ready) begin
`ifdef BACK_TO_BACK_EN
            if (bus.req_valid) begin
              a_reg <= bus.A;
              b_reg <= bus.mode ? ~bus.B : bus.B;
              carry <= bus.mode;
              idx   <= '0;
              d_reg <= '0;
              state <= RUN;
            end else begin
              rdy_reg <= 1'b1;
              state   <= IDLE;
            end
`else
            rdy_reg <= 1'b1;
            state   <= IDLE;
`endif
          end
        end
        default: begin
          rdy_reg <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_addsub16_slice_sequencer.sv
// Directed self-checking bench for addsub16_slice_sequencer (WIDTH=16, SLICE=4).
// Inputs driven and outputs sampled on the falling edge; results hand-computed.
module tb_addsub16_slice_sequencer;
  logic clk;
  logic rst;
  int   vectors = 0;
  int   errors  = 0;

  addsub16_slice_sequencer_if #(.WIDTH(16)) bus ();

  addsub16_slice_sequencer #(.WIDTH(16), .SLICE(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one request, confirm it is accepted, and check resp_valid rises exactly 4 edges later.
  task automatic send(input logic m, input logic [15:0] a, input logic [15:0] b, input string tag);
    int n;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_req_ready"}, {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.mode      = m;
    bus.A         = a;
    bus.B         = b;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.A         = ~a;
    bus.B         = ~b;
    bus.mode      = ~m;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (bus.resp_valid === 1'b1) break;
    end
    check({tag, "_latency"}, n, 32'd4);
  endtask

  task automatic check_result(input string tag, input logic [15:0] d, input logic c, input logic v);
    check({tag, "_D"}, {16'd0, bus.D}, {16'd0, d});
    check({tag, "_C_out"}, {31'd0, bus.C_out}, {31'd0, c});
    check({tag, "_V"}, {31'd0, bus.V}, {31'd0, v});
  endtask

  task automatic retire(input string tag);
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check({tag, "_retired"}, {31'd0, bus.resp_valid}, 32'd0);
  endtask

  initial begin
    logic seen;
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.mode       = 1'b0;
    bus.A          = '0;
    bus.B          = '0;
    bus.resp_ready = 1'b0;

    // 1. reset state and first ready after release
    @(negedge clk);
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);

    // 2. subtract without borrow
    send(1'b1, 16'h1234, 16'h0234, "sub1");
    check_result("sub1", 16'h1000, 1'b1, 1'b0);

    // asynchronous reset mid-cycle while holding a result
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_D", {16'd0, bus.D}, 32'd0);
    check("arst_C_out", {31'd0, bus.C_out}, 32'd0);
    check("arst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("arst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("arst_release_ready", {31'd0, bus.req_ready}, 32'd1);

    // 3. borrow and signed overflow in subtract
    send(1'b1, 16'h0000, 16'h0001, "sub_borrow");
    check_result("sub_borrow", 16'hFFFF, 1'b0, 1'b0);
    retire("sub_borrow");
    send(1'b1, 16'h8000, 16'h0001, "sub_ovf");
    check_result("sub_ovf", 16'h7FFF, 1'b1, 1'b1);
    retire("sub_ovf");

    // 4. add overflow and wrap-around
    send(1'b0, 16'h7FFF, 16'h0001, "add_ovf");
    check_result("add_ovf", 16'h8000, 1'b0, 1'b1);
    retire("add_ovf");
    send(1'b0, 16'hFFFF, 16'h0001, "add_wrap");
    check_result("add_wrap", 16'h0000, 1'b1, 1'b0);

    // 5. backpressure: outputs frozen, requests ignored
    for (int i = 0; i < 10; i++) begin
      bus.req_valid = i[0];
      bus.mode      = i[1];
      bus.A         = 16'($urandom);
      bus.B         = 16'($urandom);
      @(negedge clk);
      check("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
      check("bp_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
      check("bp_D", {16'd0, bus.D}, 32'd0);
      check("bp_C_out", {31'd0, bus.C_out}, 32'd1);
    end
    bus.req_valid = 1'b0;
`ifdef BACK_TO_BACK_EN
    bus.resp_ready = 1'b1;
    bus.req_valid  = 1'b1;
    bus.mode       = 1'b0;
    bus.A          = 16'h1111;
    bus.B          = 16'h2222;
    #1;
    check("b2b_req_ready", {31'd0, bus.req_ready}, 32'd1);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    bus.req_valid  = 1'b0;
    check("b2b_resp_valid_low", {31'd0, bus.resp_valid}, 32'd0);
    check("b2b_req_ready_low", {31'd0, bus.req_ready}, 32'd0);
    begin
      int n;
      n = 0;
      while (n < 20) begin
        @(negedge clk);
        n++;
        if (bus.resp_valid === 1'b1) break;
      end
      check("b2b_latency", n, 32'd4);
    end
    check_result("b2b", 16'h3333, 1'b0, 1'b0);
    retire("b2b");
`else
    retire("bp");
    check("bp_idle_D_kept", {16'd0, bus.D}, 32'd0);
    check("bp_idle_C_kept", {31'd0, bus.C_out}, 32'd1);
    check("bp_idle_ready", {31'd0, bus.req_ready}, 32'd1);
`endif

    // 6. reset during RUN at idx=2 abandons the transaction
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.mode      = 1'b0;
    bus.A         = 16'h4444;
    bus.B         = 16'h1111;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("run_rst_D", {16'd0, bus.D}, 32'd0);
    check("run_rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.resp_valid === 1'b1) seen = 1'b1;
    end
    check("run_rst_no_resp", {31'd0, seen}, 32'd0);
    send(1'b0, 16'h00FF, 16'h0001, "post_rst_add");
    check_result("post_rst_add", 16'h0100, 1'b0, 1'b0);
    retire("post_rst_add");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
